// File: rtl/mw_sub_seq.sv
// -----------------------------------------------------------------------------
// mw_sub_seq -- chunk-serial multi-word subtractor
//
// Computes diff = a - b (mod 2^N) as a + ~b + 1, one WIDTH-bit chunk per clock,
// least-significant chunk first, with the carry registered between chunks.
// One transaction at a time: IDLE accepts, RUN lasts NWORDS cycles, DONE holds
// the result until the consumer takes it.
//
// Parameters
//   WIDTH   chunk width in bits (>= 2)
//   NWORDS  chunks per operand (>= 2); N = WIDTH*NWORDS
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operand pair a/b valid (sampled only in IDLE)
//   in_ready   high in IDLE
//   a, b       minuend / subtrahend, N bits
//   out_valid  result valid (DONE)
//   out_ready  consumer accepts result
//   diff       a - b mod 2^N
//   cout       final carry, 1 = no borrow (a >= b unsigned)
//   zero, ovf  (only with MW_SUB_SEQ_FLAGS_EN defined) diff == 0 and signed
//              overflow, registered, valid with out_valid
//
// Build option: define MW_SUB_SEQ_FLAGS_EN to add the zero/ovf outputs.
// -----------------------------------------------------------------------------
module mw_sub_seq #(
   parameter int WIDTH  = 4,
   parameter int NWORDS = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [WIDTH*NWORDS-1:0] a,
   input  logic [WIDTH*NWORDS-1:0] b,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [WIDTH*NWORDS-1:0] diff,
   output logic                    cout
`ifdef MW_SUB_SEQ_FLAGS_EN
   ,
   output logic                    zero,
   output logic                    ovf
`endif
);

   localparam int N     = WIDTH * NWORDS;
   localparam int IDX_W = $clog2(NWORDS);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [N-1:0]       a_q, a_d;
   logic [N-1:0]       nb_q, nb_d;      // holds ~b so RUN is a plain add
   logic [N-1:0]       diff_q, diff_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               carry_q, carry_d;
   logic               cout_q, cout_d;

   logic [WIDTH-1:0]   a_chunk  [NWORDS];
   logic [WIDTH-1:0]   nb_chunk [NWORDS];
   logic [WIDTH:0]     sum;             // {c, s}
   logic               run_step;
   logic               last_step;

   assign run_step  = (state_q == RUN);
   assign last_step = run_step && (idx_q == IDX_W'(NWORDS - 1));

   // Chunk views of the operands, and per-chunk write of the result: only the
   // chunk addressed by idx changes during RUN, the rest keep their value.
   for (genvar gi = 0; gi < NWORDS; gi++) begin : g_chunk
      assign a_chunk[gi]  = a_q[gi*WIDTH +: WIDTH];
      assign nb_chunk[gi] = nb_q[gi*WIDTH +: WIDTH];
      assign diff_d[gi*WIDTH +: WIDTH] =
         (run_step && (idx_q == IDX_W'(gi))) ? sum[WIDTH-1:0]
                                             : diff_q[gi*WIDTH +: WIDTH];
   end

   assign sum = {1'b0, a_chunk[idx_q]} + {1'b0, nb_chunk[idx_q]}
              + {{WIDTH{1'b0}}, carry_q};

`ifdef MW_SUB_SEQ_FLAGS_EN
   logic zero_q, zero_d;
   logic ovf_q,  ovf_d;
`endif

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      nb_d    = nb_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      cout_d  = cout_q;
`ifdef MW_SUB_SEQ_FLAGS_EN
      zero_d  = zero_q;
      ovf_d   = ovf_q;
`endif
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = a;
               nb_d    = ~b;
               idx_d   = '0;
               carry_d = 1'b1;   // the +1 of two's-complement negation
               state_d = RUN;
            end
         end
         RUN: begin
            carry_d = sum[WIDTH];
            idx_d   = idx_q + IDX_W'(1);
            if (last_step) begin
               idx_d   = '0;
               cout_d  = sum[WIDTH];
               state_d = DONE;
`ifdef MW_SUB_SEQ_FLAGS_EN
               zero_d  = (diff_d == '0);
               // a and b differ in sign  <=>  a and ~b agree in sign
               ovf_d   = (a_q[N-1] == nb_q[N-1]) && (diff_d[N-1] != a_q[N-1]);
`endif
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         nb_q    <= '0;
         diff_q  <= '0;
         idx_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
`ifdef MW_SUB_SEQ_FLAGS_EN
         zero_q  <= 1'b0;
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         nb_q    <= nb_d;
         diff_q  <= diff_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
`ifdef MW_SUB_SEQ_FLAGS_EN
         zero_q  <= zero_d;
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign diff      = diff_q;
   assign cout      = cout_q;
`ifdef MW_SUB_SEQ_FLAGS_EN
   assign zero      = zero_q;
   assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_mw_sub_seq.sv
// -----------------------------------------------------------------------------
// tb_mw_sub_seq -- self-checking bench for mw_sub_seq (WIDTH=4, NWORDS=4).
// Expected results come from plain arithmetic on the operands: a - b mod 2^16,
// carry = (a >= b), and, with MW_SUB_SEQ_FLAGS_EN, zero/ovf from the sign bits.
// -----------------------------------------------------------------------------
module tb_mw_sub_seq;

   localparam int WIDTH  = 4;
   localparam int NWORDS = 4;
   localparam int N      = WIDTH * NWORDS;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] a, b;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] diff;
   logic         cout;
`ifdef MW_SUB_SEQ_FLAGS_EN
   logic         zero, ovf;
`endif

   int errors = 0;
   int checks = 0;

   mw_sub_seq #(.WIDTH(WIDTH), .NWORDS(NWORDS)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .cout      (cout)
`ifdef MW_SUB_SEQ_FLAGS_EN
      ,
      .zero      (zero),
      .ovf       (ovf)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference model
   function automatic logic [N-1:0] ref_diff(input logic [N-1:0] x, input logic [N-1:0] y);
      logic [N:0] full;
      full = {1'b0, x} - {1'b0, y};
      return full[N-1:0];
   endfunction

   function automatic logic ref_cout(input logic [N-1:0] x, input logic [N-1:0] y);
      return (x >= y);
   endfunction

   function automatic logic ref_ovf(input logic [N-1:0] x, input logic [N-1:0] y);
      logic [N-1:0] d;
      d = ref_diff(x, y);
      return (x[N-1] != y[N-1]) && (d[N-1] != x[N-1]);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full transaction: accept, measure latency, check result, hold
   // out_ready low for 'hold' cycles while poking in_valid, then release.
   task automatic run_txn(input logic [N-1:0] xa, input logic [N-1:0] xb, input int hold);
      int lat;
      logic [N-1:0] ed;
      logic         ec;
      ed = ref_diff(xa, xb);
      ec = ref_cout(xa, xb);
      chk("in_ready_idle", 32'(in_ready), 32'd1);
      a = xa; b = xb; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      a = N'($urandom); b = N'($urandom);
      chk("in_ready_run", 32'(in_ready), 32'd0);
      lat = 0;
      while (!out_valid && lat < 20) begin
         tick();
         lat++;
      end
      chk("latency", 32'(lat), 32'(NWORDS));
      chk("diff", 32'(diff), 32'(ed));
      chk("cout", 32'(cout), 32'(ec));
`ifdef MW_SUB_SEQ_FLAGS_EN
      chk("zero", 32'(zero), 32'(ed == '0));
      chk("ovf", 32'(ovf), 32'(ref_ovf(xa, xb)));
`endif
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'b1;           // must be ignored in DONE
         a = N'($urandom); b = N'($urandom);
         tick();
         chk("hold_valid", 32'(out_valid), 32'd1);
         chk("hold_ready", 32'(in_ready), 32'd0);
         chk("hold_diff", 32'(diff), 32'(ed));
         chk("hold_cout", 32'(cout), 32'(ec));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("release_valid", 32'(out_valid), 32'd0);
      chk("release_ready", 32'(in_ready), 32'd1);
      $display("txn a=0x%04h b=0x%04h diff=0x%04h cout=%0d lat=%0d hold=%0d",
               xa, xb, diff, cout, lat, hold);
   endtask

   initial begin
      logic [N-1:0] pa [$];
      logic [N-1:0] pb [$];
      logic [N-1:0] qa, qb;
      logic         acc;
      int           last_out;
      int           nres;

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_diff", 32'(diff), 32'd0);
      chk("rst_cout", 32'(cout), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef MW_SUB_SEQ_FLAGS_EN
      chk("rst_zero", 32'(zero), 32'd0);
      chk("rst_ovf", 32'(ovf), 32'd0);
`endif
      tick(); tick();
      rst_n = 1'b1;
      tick();

      // Directed vectors
      run_txn(16'h1234, 16'h0234, 0);
      run_txn(16'h0000, 16'h0001, 0);
      run_txn(16'h8000, 16'h0001, 1);
      run_txn(16'hA5A5, 16'hA5A5, 0);
      run_txn(16'hFFFF, 16'h0000, 0);
      run_txn(16'h1234, 16'h5678, 5);

      // Reset in the middle of RUN (idx = 2)
      a = 16'h7777; b = 16'h1111; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick(); tick();
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_diff", 32'(diff), 32'd0);
      chk("midrst_cout", 32'(cout), 32'd0);
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("midrst_no_result", 32'(out_valid), 32'd0);
      end
      run_txn(16'h0010, 16'h0001, 0);

      // Random transactions with random consumer stall
      for (int i = 0; i < 20; i++) begin
         run_txn(N'($urandom), N'($urandom), int'($urandom_range(0, 3)));
      end

      // Back-to-back: in_valid and out_ready held high, operands change
      // every cycle; a scoreboard records what each accepting edge saw.
      in_valid = 1'b1; out_ready = 1'b1;
      last_out = -1; nres = 0;
      for (int cyc = 0; cyc < 70; cyc++) begin
         a = N'($urandom); b = N'($urandom);
         acc = in_ready;
         qa = a; qb = b;
         tick();
         if (acc) begin
            pa.push_back(qa);
            pb.push_back(qb);
         end
         if (out_valid) begin
            if (pa.size() == 0) begin
               chk("b2b_unexpected_result", 32'd1, 32'd0);
            end else begin
               qa = pa.pop_front(); qb = pb.pop_front();
               chk("b2b_diff", 32'(diff), 32'(ref_diff(qa, qb)));
               chk("b2b_cout", 32'(cout), 32'(ref_cout(qa, qb)));
               $display("b2b a=0x%04h b=0x%04h diff=0x%04h cout=%0d cyc=%0d",
                        qa, qb, diff, cout, cyc);
            end
            if (last_out >= 0) chk("b2b_period", 32'(cyc - last_out), 32'(NWORDS + 2));
            last_out = cyc;
            nres++;
         end
      end
      in_valid = 1'b0; out_ready = 1'b0;
      chk("b2b_result_count", 32'(nres >= 10), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Absolute time limit so the run always terminates.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
